// File: rtl/jtkunio_colmix_if.sv
`default_nettype none
// ============================================================================
// Module   : jtkunio_colmix_if
// Purpose  : CPU palette bus between the main CPU and the colour mixer.
// Revision : 1.0
// ============================================================================
interface jtkunio_colmix_if;
  logic [8:0] cpu_addr;
  logic       pal_cs;
  logic       cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;

  modport master (output cpu_addr, pal_cs, cpu_wrn, cpu_dout, input  cpu_din);
  modport slave  (input  cpu_addr, pal_cs, cpu_wrn, cpu_dout, output cpu_din);
endinterface
`default_nettype wire

// File: rtl/jtkunio_colmix.sv
`default_nettype none
// ============================================================================
// Module   : jtkunio_colmix
// Purpose  : Layer priority, 256x12 CPU-writable palette and blanked RGB444.
// Revision : 1.0
// ============================================================================
module jtkunio_colmix #(
  parameter SIMFILE_LO = "pal_lo.bin",
  parameter SIMFILE_HI = "pal_hi.bin"
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pxl_cen,
  input  logic                    LHBL,
  input  logic                    LVBL,
  input  logic [4:0]              char_pxl,
  input  logic [5:0]              scr_pxl,
  input  logic [6:0]              obj_pxl,
  input  logic [2:0]              gfx_en,
  jtkunio_colmix_if.slave         cpu,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    LHBL_dly,
  output logic                    LVBL_dly
);

  logic       w_char_op, w_scr_op, w_obj_op;
  logic [7:0] w_idx;
  logic       w_we_rg, w_we_b;
  logic       w_unused;

  logic [7:0] r_pal_idx;
  logic       r_lhbl_d1, r_lvbl_d1;
  logic       r_rd_en;
  logic [7:0] r_mem_rg [0:255];
  logic [3:0] r_mem_b  [0:255];
  logic [7:0] r_cpu_rg;
  logic [3:0] r_cpu_b;
  logic       r_cpu_bank;
  logic [7:0] r_vid_rg;
  logic [3:0] r_vid_b;

  assign w_char_op = (char_pxl[2:0] != 3'd0) & gfx_en[0];
  assign w_scr_op  = (scr_pxl[2:0]  != 3'd0) & gfx_en[1];
  assign w_obj_op  = (obj_pxl[2:0]  != 3'd0) & gfx_en[2];

  always_comb begin
    w_idx = 8'h00;
    if (w_char_op)     w_idx = {3'b000, char_pxl};
    else if (w_obj_op) w_idx = {1'b1, obj_pxl};
    else if (w_scr_op) w_idx = {2'b01, scr_pxl};
  end

  assign w_we_rg  = cpu.pal_cs & ~cpu.cpu_wrn & ~cpu.cpu_addr[8];
  assign w_we_b   = cpu.pal_cs & ~cpu.cpu_wrn &  cpu.cpu_addr[8];
  assign w_unused = ^cpu.cpu_dout[7:4];

  // Both ports sample the array before this edge's write lands, so a
  // colliding read (CPU or video) returns the old entry.
  always_ff @(posedge clk) begin
    if (w_we_rg) r_mem_rg[cpu.cpu_addr[7:0]] <= cpu.cpu_dout;
    if (w_we_b)  r_mem_b[cpu.cpu_addr[7:0]]  <= cpu.cpu_dout[3:0];
    r_cpu_rg   <= r_mem_rg[cpu.cpu_addr[7:0]];
    r_cpu_b    <= r_mem_b[cpu.cpu_addr[7:0]];
    r_cpu_bank <= cpu.cpu_addr[8];
    if (r_rd_en) begin
      r_vid_rg <= r_mem_rg[r_pal_idx];
      r_vid_b  <= r_mem_b[r_pal_idx];
    end
  end

  assign cpu.cpu_din = r_cpu_bank ? {4'b0000, r_cpu_b} : r_cpu_rg;

  // Video read fires once per pixel, on the clk right after pal_idx moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pal_idx <= 8'h00;
      r_lhbl_d1 <= 1'b0;
      r_lvbl_d1 <= 1'b0;
      r_rd_en   <= 1'b0;
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      LHBL_dly  <= 1'b0;
      LVBL_dly  <= 1'b0;
    end else begin
      r_rd_en <= pxl_cen;
      if (pxl_cen) begin
        r_pal_idx <= w_idx;
        r_lhbl_d1 <= LHBL;
        r_lvbl_d1 <= LVBL;
        LHBL_dly  <= r_lhbl_d1;
        LVBL_dly  <= r_lvbl_d1;
        if (r_lhbl_d1 & r_lvbl_d1) begin
          red   <= r_vid_rg[3:0];
          green <= r_vid_rg[7:4];
          blue  <= r_vid_b;
        end else begin
          red   <= 4'h0;
          green <= 4'h0;
          blue  <= 4'h0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtkunio_colmix.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtkunio_colmix
// Purpose  : Self-checking bench for the colour mixer with a palette model.
// Revision : 1.0
// ============================================================================
module tb_jtkunio_colmix;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0, LVBL = 1'b0;
  logic [4:0] char_pxl = '0;
  logic [5:0] scr_pxl = '0;
  logic [6:0] obj_pxl = '0;
  logic [2:0] gfx_en = 3'b111;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtkunio_colmix_if cpu_bus();

  jtkunio_colmix dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .char_pxl (char_pxl),
    .scr_pxl  (scr_pxl),
    .obj_pxl  (obj_pxl),
    .gfx_en   (gfx_en),
    .cpu      (cpu_bus),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pal_rg [0:255];
  logic [3:0]  pal_b  [0:255];
  logic [13:0] exp_q  [$];

  typedef struct packed {
    logic [4:0] c;
    logic [5:0] s;
    logic [6:0] o;
    logic [2:0] en;
    logic [7:0] idx;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int ref_idx(input logic [4:0] c, input logic [5:0] s,
                                 input logic [6:0] o, input logic [2:0] en);
    if (en[0] && c % 8 != 0) return int'(c);
    if (en[2] && o % 8 != 0) return 128 + int'(o);
    if (en[1] && s % 8 != 0) return 64 + int'(s);
    return 0;
  endfunction

  function automatic logic [11:0] colour(input int idx);
    return {pal_rg[idx][3:0], pal_rg[idx][7:4], pal_b[idx]};
  endfunction

  task automatic shadow_write(input logic [8:0] a, input logic [7:0] d);
    if (a[8]) pal_b[a[7:0]] = d[3:0];
    else      pal_rg[a[7:0]] = d;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_bus.cpu_addr = a; cpu_bus.cpu_dout = d;
    cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_wrn = 1'b0;
    @(negedge clk);
    cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_wrn = 1'b1;
    shadow_write(a, d);
  endtask

  task automatic cpu_read(input string name, input logic [8:0] a, input logic [7:0] exp);
    @(negedge clk);
    cpu_bus.cpu_addr = a;
    @(negedge clk);
    chk(name, cpu_bus.cpu_din, exp);
  endtask

  // One pixel: present layers, pulse pxl_cen, optionally write on the very
  // next clk (the video read clk), and compare against the previous pixel.
  task automatic do_pixel(input logic [4:0] c, input logic [5:0] s, input logic [6:0] o,
                          input logic [2:0] en, input logic lh, input logic lv,
                          input int exp_idx, input logic wr = 1'b0,
                          input logic [8:0] wa = 9'h0, input logic [7:0] wd = 8'h0);
    int idx;
    logic [13:0] got;
    idx = (exp_idx >= 0) ? exp_idx : ref_idx(c, s, o, en);
    exp_q.push_back({(lh && lv) ? colour(idx) : 12'h000, lh, lv});
    @(negedge clk);
    char_pxl = c; scr_pxl = s; obj_pxl = o; gfx_en = en; LHBL = lh; LVBL = lv;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    if (wr) begin
      cpu_bus.cpu_addr = wa; cpu_bus.cpu_dout = wd;
      cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_wrn = 1'b0;
    end
    got = {red, green, blue, LHBL_dly, LVBL_dly};
    chk("pixel_rgb_blank", got, exp_q.pop_front());
    @(negedge clk);
    cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_wrn = 1'b1;
    if (wr) shadow_write(wa, wd);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] old_rg, rd;
    cpu_bus.cpu_addr = '0; cpu_bus.cpu_dout = '0;
    cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_wrn = 1'b1;

    vecs[0] = '{5'h00, 6'h09, 7'h15, 3'b111, 8'h95};
    vecs[1] = '{5'h02, 6'h09, 7'h15, 3'b111, 8'h02};
    vecs[2] = '{5'h00, 6'h09, 7'h10, 3'b111, 8'h49};
    vecs[3] = '{5'h00, 6'h00, 7'h00, 3'b111, 8'h00};
    vecs[4] = '{5'h02, 6'h09, 7'h15, 3'b110, 8'h95};
    vecs[5] = '{5'h00, 6'h09, 7'h15, 3'b011, 8'h49};
    vecs[6] = '{5'h1F, 6'h3F, 7'h7F, 3'b001, 8'h1F};
    vecs[7] = '{5'h08, 6'h08, 7'h08, 3'b111, 8'h00};
    vecs[8] = '{5'h00, 6'h00, 7'h7F, 3'b100, 8'hFF};
    vecs[9] = '{5'h00, 6'h3F, 7'h00, 3'b010, 8'h7F};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'h0, red, green, blue, LHBL_dly, LVBL_dly}, 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(14'h0);

    for (int i = 0; i < 256; i++) begin
      cpu_write({1'b0, 8'(i)}, 8'(i) ^ 8'hA5);
      cpu_write({1'b1, 8'(i)}, 8'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      int a;
      a = $urandom_range(0, 255);
      cpu_read("readback_rg", {1'b0, 8'(a)}, pal_rg[a]);
      cpu_read("readback_b", {1'b1, 8'(a)}, {4'h0, pal_b[a]});
    end

    cpu_write(9'h003, 8'h5A);
    cpu_write(9'h103, 8'hF7);
    cpu_read("readback_5a", 9'h003, 8'h5A);
    cpu_read("readback_07", 9'h103, 8'h07);
    do_pixel(5'h03, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, 3);
    do_pixel(5'h03, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, 3);
    chk("rgb_A57", {20'h0, red, green, blue}, 32'hA57);

    foreach (vecs[i])
      do_pixel(vecs[i].c, vecs[i].s, vecs[i].o, vecs[i].en, 1'b1, 1'b1, int'(vecs[i].idx));

    // Blanking window: three pixels with LHBL low, then back high.
    for (int i = 0; i < 9; i++)
      do_pixel(5'h03, 6'h00, 7'h00, 3'b111, !(i >= 2 && i < 5), 1'b1, -1);
    do_pixel(5'h00, 6'h00, 7'h15, 3'b111, 1'b1, 1'b0, -1);
    do_pixel(5'h00, 6'h00, 7'h15, 3'b111, 1'b1, 1'b1, -1);

    // Write collision on the video read clk.
    old_rg = pal_rg[2];
    do_pixel(5'h02, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1, 1'b1, 9'h002, ~old_rg);
    do_pixel(5'h02, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1);
    chk("collision_old", {28'h0, red}, {28'h0, old_rg[3:0]});
    do_pixel(5'h02, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1);
    rd = ~old_rg;
    chk("collision_new", {28'h0, red}, {28'h0, rd[3:0]});

    // Asynchronous reset between pulses.
    do_pixel(5'h03, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1);
    do_pixel(5'h03, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1);
    chk("pre_reset_rgb", {20'h0, red, green, blue}, 32'hA57);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {18'h0, red, green, blue, LHBL_dly, LVBL_dly}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(14'h0);
    cpu_read("survive_rg", 9'h003, 8'h5A);
    cpu_read("survive_b", 9'h103, 8'h07);
    cpu_read("survive_2", 9'h002, ~old_rg);
    do_pixel(5'h03, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1);
    do_pixel(5'h03, 6'h00, 7'h00, 3'b111, 1'b1, 1'b1, -1);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] en;
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(0, 9) == 0)
        cpu_write(9'($urandom), 8'($urandom));
      do_pixel(5'($urandom), 6'($urandom), 7'($urandom), en,
               $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
